// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the shift-and-add multiplier control unit.
//   mult_state_t   : 3-bit state encoding of the control FSM
//   OUT_*          : per-state strobe vectors, packed as {count, lm, lp, sm}
//   state_outputs(): Moore decode from a state to its strobe vector
// -----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ADD    = 3'd2,
        SHIFT  = 3'd3,
        FINISH = 3'd4
    } mult_state_t;

    // Strobe vectors, bit order {count, lm, lp, sm}
    localparam logic [3:0] OUT_IDLE   = 4'b0000;
    localparam logic [3:0] OUT_LOAD   = 4'b0110;
    localparam logic [3:0] OUT_ADD    = 4'b0010;
    localparam logic [3:0] OUT_SHIFT  = 4'b1001;
    localparam logic [3:0] OUT_FINISH = 4'b0000;

    // Unused encodings decode to all-zero strobes so a corrupted state can
    // never disturb the datapath before it falls back to IDLE.
    function automatic logic [3:0] state_outputs(input mult_state_t s);
        logic [3:0] v;
        v = OUT_IDLE;
        case (s)
            IDLE:    v = OUT_IDLE;
            LOAD:    v = OUT_LOAD;
            ADD:     v = OUT_ADD;
            SHIFT:   v = OUT_SHIFT;
            FINISH:  v = OUT_FINISH;
            default: v = OUT_IDLE;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mult_control_fsm.sv
// -----------------------------------------------------------------------------
// mult_control_fsm
// Moore control FSM for the sequential shift-and-add multiplier. Loads the
// operands, then alternates ADD and SHIFT until the datapath counter reports
// done, then parks in FINISH until start is released.
// Ports:
//   count (out) : increment the datapath iteration counter
//   lm    (out) : load multiplicand register
//   lp    (out) : load/write product register
//   sm    (out) : shift product/multiplier register right by one
//   clk   (in)  : clock, rising edge
//   start (in)  : level request to begin a multiplication
//   done  (in)  : iteration counter has reached its final value
//   rst   (in)  : asynchronous active-high reset
// -----------------------------------------------------------------------------
module mult_control_fsm
    import mult_pkg::*;
(
    output logic count,
    output logic lm,
    output logic lp,
    output logic sm,
    input  logic clk,
    input  logic start,
    input  logic done,
    input  logic rst
);

    mult_state_t state_q;
    mult_state_t state_d;
    logic [3:0]  strobes;

    // State register; reset takes effect immediately, not on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. start is only looked at in IDLE/FINISH and done only
    // in SHIFT, so dropping start mid-operation never aborts it.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
            LOAD:    state_d = ADD;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = done ? FINISH : ADD;
            // Waiting for start to fall prevents retriggering on a held start.
            FINISH:  state_d = start ? FINISH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the registered state only.
    always_comb begin
        strobes = state_outputs(state_q);
    end

    assign {count, lm, lp, sm} = strobes;

endmodule

// File: tb/tb_mult_control_fsm.sv
module tb_mult_control_fsm;

    logic clk;
    logic rst;
    logic start;
    logic done;
    logic count;
    logic lm;
    logic lp;
    logic sm;

    int checks;
    int errors;
    logic [3:0] exp_q[$];

    mult_control_fsm dut (
        .count (count),
        .lm    (lm),
        .lp    (lp),
        .sm    (sm),
        .clk   (clk),
        .start (start),
        .done  (done),
        .rst   (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus entries are {start, done, expected {count,lm,lp,sm} after the edge}.

    task automatic test_reset();
        logic [3:0] got;
        logic [5:0] seq [5] = '{
            6'b10_0110,   // start seen after reset release -> LOAD
            6'b00_0010,   // ADD
            6'b01_1001,   // SHIFT
            6'b01_0000,   // done in SHIFT -> FINISH
            6'b00_0000    // start low -> IDLE
        };
        rst = 1'b1; start = 1'b1; done = 1'b0;
        #1;
        got = {count, lm, lp, sm};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL reset_initial got %b exp %b", got, 4'b0000);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            got = {count, lm, lp, sm};
            checks++;
            if (got !== 4'b0000) begin
                errors++;
                $display("FAIL reset_held cycle %0d got %b exp %b", i, got, 4'b0000);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = seq[i][5]; done = seq[i][4];
            exp_q.push_back(seq[i][3:0]);
            @(posedge clk); #1;
            got = {count, lm, lp, sm};
            checks++;
            if (got !== exp_q[0]) begin
                errors++;
                $display("FAIL reset_release step %0d got %b exp %b", i, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        $display("test_reset done");
    endtask

    task automatic test_single_iter();
        logic [3:0] got;
        logic [5:0] seq [7] = '{
            6'b11_0110, 6'b11_0010, 6'b11_1001,
            6'b11_0000, 6'b11_0000, 6'b11_0000,
            6'b00_0000
        };
        for (int i = 0; i < 7; i++) begin
            start = seq[i][5]; done = seq[i][4];
            exp_q.push_back(seq[i][3:0]);
            @(posedge clk); #1;
            got = {count, lm, lp, sm};
            checks++;
            if (got !== exp_q[0]) begin
                errors++;
                $display("FAIL single_iter step %0d got %b exp %b", i, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        $display("test_single_iter done");
    endtask

    task automatic test_multi_iter();
        logic [3:0] got;
        int n_count, n_lm, n_lp, n_sm;
        logic [5:0] seq [11] = '{
            6'b10_0110,                             // LOAD
            6'b00_0010, 6'b00_1001,                 // iter 1
            6'b00_0010, 6'b00_1001,                 // iter 2
            6'b00_0010, 6'b00_1001,                 // iter 3
            6'b00_0010, 6'b00_1001,                 // iter 4
            6'b01_0000,                             // done in 4th SHIFT -> FINISH
            6'b00_0000                              // IDLE
        };
        n_count = 0; n_lm = 0; n_lp = 0; n_sm = 0;
        for (int i = 0; i < 11; i++) begin
            start = seq[i][5]; done = seq[i][4];
            exp_q.push_back(seq[i][3:0]);
            @(posedge clk); #1;
            got = {count, lm, lp, sm};
            n_count += int'(count); n_lm += int'(lm); n_lp += int'(lp); n_sm += int'(sm);
            checks++;
            if (got !== exp_q[0]) begin
                errors++;
                $display("FAIL multi_iter step %0d got %b exp %b", i, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        checks++;
        if (n_count != 4) begin errors++; $display("FAIL multi_count_pulses got %0d exp 4", n_count); end
        checks++;
        if (n_sm != 4) begin errors++; $display("FAIL multi_sm_pulses got %0d exp 4", n_sm); end
        checks++;
        if (n_lp != 5) begin errors++; $display("FAIL multi_lp_pulses got %0d exp 5", n_lp); end
        checks++;
        if (n_lm != 1) begin errors++; $display("FAIL multi_lm_pulses got %0d exp 1", n_lm); end
        $display("test_multi_iter done");
    endtask

    task automatic test_no_retrigger();
        logic [3:0] got;
        logic [5:0] seq [12] = '{
            6'b11_0110, 6'b11_0010, 6'b11_1001,
            6'b11_0000, 6'b11_0000, 6'b11_0000, 6'b11_0000,  // held in FINISH
            6'b00_0000,                                       // -> IDLE
            6'b10_0110,                                       // new LOAD
            6'b01_0010, 6'b01_1001, 6'b01_0000
        };
        for (int i = 0; i < 12; i++) begin
            start = seq[i][5]; done = seq[i][4];
            exp_q.push_back(seq[i][3:0]);
            @(posedge clk); #1;
            got = {count, lm, lp, sm};
            checks++;
            if (got !== exp_q[0]) begin
                errors++;
                $display("FAIL no_retrigger step %0d got %b exp %b", i, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        start = 1'b0; done = 1'b0;
        @(posedge clk); #1;
        $display("test_no_retrigger done");
    endtask

    task automatic test_abort();
        logic [3:0] got;
        logic [5:0] pre [2] = '{ 6'b10_0110, 6'b00_0010 };
        logic [5:0] post [8] = '{
            6'b01_0000, 6'b01_0000, 6'b01_0000,   // idle, done ignored
            6'b10_0110, 6'b01_0010, 6'b01_1001, 6'b01_0000,
            6'b00_0000
        };
        for (int i = 0; i < 2; i++) begin
            start = pre[i][5]; done = pre[i][4];
            exp_q.push_back(pre[i][3:0]);
            @(posedge clk); #1;
            got = {count, lm, lp, sm};
            checks++;
            if (got !== exp_q[0]) begin
                errors++;
                $display("FAIL abort_pre step %0d got %b exp %b", i, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        // Now in ADD; reset mid-cycle must clear outputs before the next edge.
        rst = 1'b1;
        #1;
        got = {count, lm, lp, sm};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL abort_immediate got %b exp %b", got, 4'b0000);
        end
        @(posedge clk); #1;
        got = {count, lm, lp, sm};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL abort_held got %b exp %b", got, 4'b0000);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            start = post[i][5]; done = post[i][4];
            exp_q.push_back(post[i][3:0]);
            @(posedge clk); #1;
            got = {count, lm, lp, sm};
            checks++;
            if (got !== exp_q[0]) begin
                errors++;
                $display("FAIL abort_post step %0d got %b exp %b", i, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        $display("test_abort done");
    endtask

    task automatic test_ignored_done();
        logic [3:0] got;
        logic [5:0] seq [9] = '{
            6'b01_0000, 6'b01_0000,   // IDLE with done high
            6'b11_0110,               // LOAD
            6'b01_0010,               // done in LOAD ignored -> ADD
            6'b01_1001,               // done in ADD ignored -> SHIFT
            6'b00_0010,               // done low in SHIFT -> ADD
            6'b01_1001,               // SHIFT
            6'b01_0000,               // done in SHIFT -> FINISH
            6'b00_0000                // IDLE
        };
        for (int i = 0; i < 9; i++) begin
            start = seq[i][5]; done = seq[i][4];
            exp_q.push_back(seq[i][3:0]);
            @(posedge clk); #1;
            got = {count, lm, lp, sm};
            checks++;
            if (got !== exp_q[0]) begin
                errors++;
                $display("FAIL ignored_done step %0d got %b exp %b", i, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        $display("test_ignored_done done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_iter();
        test_multi_iter();
        test_no_retrigger();
        test_abort();
        test_ignored_done();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
